pipeline_ctrl_sequencer: RTL and testbench
==========================================

# pipeline_ctrl_sequencer

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines load-use hazard stalls, taken-branch flushes and a multi-cycle data-memory req/ready handshake into one set of pipeline-register write enables, flush and bubble strobes. It has a timeout watchdog that halts the core on a hung memory. It sits beside the ID stage, consumes IF/ID, ID/EX and EX/MEM fields, and drives every pipeline register enable plus the PC enable.

## Interface
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before error; legal range 2..255.
- CNT_W, 32: width of performance counters.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID
- ID_EX_rd  in  5  destination register of the instruction in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- EX_branch_taken  in  1  branch resolved taken in EX this cycle
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  MEM-stage access request
- mem_ready  in  1  data memory completes access this cycle
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1 each  register enables
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Bubble  out  1  zero all control fields into ID/EX
- mem_req  out  1  data-memory request
- mem_err  out  1  sticky timeout flag
- stall_cycles, flush_count  out  CNT_W each  present only with PERF_CNT_EN

## Operation
- States: RUN, MEM_WAIT, HALT. Reset → RUN.
- Priority per cycle: HALT > memory stall > branch flush > load-use stall.
- mem_req = (EX_MEM_MemRead | EX_MEM_MemWrite) in RUN or MEM_WAIT; 0 in HALT.
- Memory stall: access pending and mem_ready=0. All five enables = 0, IF_ID_Flush = 0, ID_EX_Bubble = 0. The pipeline freezes, and any branch or load-use condition is re-presented later. Next state is MEM_WAIT.
- In MEM_WAIT:
  - mem_ready=1: that cycle is evaluated exactly as RUN with the access complete, then next state is RUN.
  - mem_ready=0: wait_cnt increments. If wait_cnt == MEM_TIMEOUT-1, next state is HALT.
- Branch flush (EX_branch_taken, no memory stall):
  - All enables = 1, IF_ID_Flush = 1, ID_EX_Bubble = 1.
  - The load-use stall is ignored because the stalled instruction is wrong-path.
- Load-use stall: ID_EX_MemRead & ID_EX_rd≠0 & (rd==rs1 | rd==rs2).
  - PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1.
  - ID_EX_Write, EX_MEM_Write and MEM_WB_Write = 1.
- No condition: all enables = 1, strobes = 0.
- HALT: all enables = 0, strobes = 0, mem_req = 0. mem_err = 1 until reset.
- wait_cnt is 8 bits. It clears on every entry to MEM_WAIT and on exit from it.

## Timing
- Enables, strobes and mem_req are combinational from state + inputs (same-cycle). State, wait_cnt, mem_err and counters are registered.
- While reset=1:
  - All enables = 0; IF_ID_Flush = 1, ID_EX_Bubble = 1.
  - mem_req = 0, mem_err = 0, counters = 0.
  - Reset in any state, including mid-MEM_WAIT or HALT, returns to RUN on the next edge.
- Zero-wait memory (mem_ready=1 in the first cycle of mem_req): no stall cycle.
- Access with ready after N cycles costs N frozen cycles.
- Timeout: HALT is entered on the edge after MEM_TIMEOUT consecutive MEM_WAIT cycles without ready. mem_err rises on that same edge.
- Load-use costs exactly 1 bubble; the second cycle sees ID_EX_MemRead=0.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with PC_Write=0 outside reset, including HALT.
  - flush_count increments on each cycle with IF_ID_Flush=1 outside reset.
  - Both wrap modulo 2^CNT_W.
- Not defined: both ports and counters are absent; the rest of the behaviour is identical.

## Structure
- pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, HALT), opcode constants (R 0110011, I 0010011, LD 0000011, SD 0100011, BEQ 1100011), and the default MEM_TIMEOUT.
- Sub-module load_use_detect: combinational hazard compare producing a single stall_req.
- FSM and counters live in the top module.

## Test plan
- **Load-use:** ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 → PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle. rd=0 instead → no stall.
- **Branch beats load-use:** EX_branch_taken=1 with the load-use condition true → IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1.
- **Memory wait:** EX_MEM_MemRead=1, mem_ready low 3 cycles then high → all enables 0 for 3 cycles, mem_req high 4 cycles, RUN on cycle 5.
- **Memory stall masks branch:** EX_branch_taken=1 during the stall → no flush until mem_ready=1, then flush in the release cycle.
- **Timeout:** MEM_TIMEOUT=4, mem_ready held 0 → HALT after 4 MEM_WAIT cycles, mem_err=1, mem_req=0. Reset → RUN, mem_err=0.
- **PIPE_PERF_CNT_EN:** 3 stall cycles + 2 flushes → stall_cycles=3, flush_count=2. With CNT_W=4, 17 flushes → flush_count=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t          : sequencer FSM states (RUN, MEM_WAIT, HALT)
//   OPC_*            : RV32I major opcodes seen by the surrounding pipeline
//   MEM_TIMEOUT_DEF  : default MEM_WAIT cycle budget before the core halts
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare.
//   rs1, rs2  : source registers of the instruction in ID
//   rd        : destination register of the instruction in EX
//   mem_read  : instruction in EX is a load
//   stall_req : ID must hold one cycle while a bubble enters EX
module load_use_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       mem_read,
  output logic       stall_req
);

  // x0 is hardwired to zero, so a load "into" x0 never creates a hazard.
  assign stall_req = mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// Central stall/flush sequencer for the 5-stage RISC-V pipeline.
// Merges memory-wait stalls, taken-branch flushes and load-use stalls into
// pipeline-register enables plus flush/bubble strobes, and halts the core when
// data memory fails to answer within MEM_TIMEOUT MEM_WAIT cycles.
// Priority: HALT > memory stall > branch flush > load-use stall.
//
// Handshake: mem_req is a level request held while an EX/MEM access is
// pending; the access completes in the cycle where mem_req && mem_ready.
// Until then the whole pipeline is frozen (all enables low).
//
// Ports:
//   clk, reset (sync, active-high)
//   IF_ID_rs1/rs2, ID_EX_rd, ID_EX_MemRead     : load-use hazard inputs
//   EX_branch_taken                            : branch resolved taken in EX
//   EX_MEM_MemRead/MemWrite, mem_ready         : data-memory access handshake
//   PC_Write..MEM_WB_Write                     : register write enables
//   IF_ID_Flush, ID_EX_Bubble                  : flush / bubble strobes
//   mem_req, mem_err                           : memory request, sticky timeout
//   fsm_state                                  : current FSM state (debug)
//   stall_cycles, flush_count                  : perf counters, only when
//                                                PIPE_PERF_CNT_EN is defined
module pipeline_ctrl_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             mem_req,
  output logic             mem_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
`endif
  output state_t           fsm_state
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_params
    $error("pipeline_ctrl_sequencer: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
  end

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       lu_stall;
  logic       pending;
  logic       mem_stall;

  load_use_detect u_load_use_detect (
    .rs1       (IF_ID_rs1),
    .rs2       (IF_ID_rs2),
    .rd        (ID_EX_rd),
    .mem_read  (ID_EX_MemRead),
    .stall_req (lu_stall)
  );

  assign pending   = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign mem_stall = pending & ~mem_ready;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    mem_req      = 1'b0;
    state_next   = state;

    if (reset) begin
      {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write} = 5'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_next   = RUN;
    end else if (state == HALT) begin
      {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write} = 5'b0;
    end else begin
      // RUN and MEM_WAIT share one evaluation; a ready cycle in MEM_WAIT
      // behaves exactly like RUN with the access completed.
      mem_req = pending;
      if (mem_stall) begin
        {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write} = 5'b0;
        if (state == RUN)
          state_next = MEM_WAIT;
        else if (wait_cnt == WAIT_LAST)
          state_next = HALT;
      end else begin
        state_next = RUN;
        if (EX_branch_taken) begin
          // A load-use stall against a wrong-path instruction is moot.
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
        end else if (lu_stall) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      // Counts only consecutive MEM_WAIT cycles; any entry or exit clears it.
      if (state == MEM_WAIT && state_next == MEM_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
      if (state_next == HALT)
        err_q <= 1'b1;
    end
  end

  // Gated so the flag reads low for the whole reset pulse, not only after it.
  assign mem_err   = err_q & ~reset;
  assign fsm_state = state;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_Write)
        stall_cycles <= stall_cycles + 1'b1;
      if (IF_ID_Flush)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Self-checking bench for pipeline_ctrl_sequencer (MEM_TIMEOUT=4, CNT_W=4).
// Output word layout used throughout:
//   {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
//    IF_ID_Flush, ID_EX_Bubble, mem_req}
// Optional feature macro: PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl_sequencer;
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] O_RUN   = 8'hF8;  // all enables, no strobes
  localparam logic [7:0] O_RUNR  = 8'hF9;  // ... with mem_req
  localparam logic [7:0] O_LU    = 8'h3A;  // load-use stall
  localparam logic [7:0] O_LUR   = 8'h3B;
  localparam logic [7:0] O_FL    = 8'hFE;  // branch flush
  localparam logic [7:0] O_FLR   = 8'hFF;
  localparam logic [7:0] O_STALL = 8'h01;  // memory stall: frozen, req high
  localparam logic [7:0] O_HALT  = 8'h00;
  localparam logic [7:0] O_RST   = 8'h06;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic ID_EX_MemRead, EX_branch_taken, EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready;
  logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
  logic IF_ID_Flush, ID_EX_Bubble, mem_req, mem_err;
  state_t fsm_state;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0] stall_cycles, flush_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  pipeline_ctrl_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .EX_branch_taken(EX_branch_taken),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .mem_ready(mem_ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Write(MEM_WB_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .mem_req(mem_req), .mem_err(mem_err),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic mr, input logic mw, input logic rdy);
    IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; ID_EX_rd = rd; ID_EX_MemRead = ld;
    EX_branch_taken = br; EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  // Push the expected output word, sample at the falling edge, score it along
  // with state and mem_err, then move to just after the next rising edge.
  task automatic step(input logic [7:0] exp_out, input state_t exp_st,
                      input logic exp_err, input string name);
    logic [7:0] got, e;
    exp_q.push_back(exp_out);
    @(negedge clk);
    got = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Bubble, mem_req};
    e = exp_q.pop_front();
    check({name, ".out"}, got, e);
    check({name, ".state"}, 8'(fsm_state), 8'(exp_st));
    check({name, ".err"}, {7'd0, mem_err}, {7'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(O_RST, RUN, 1'b0, "reset");
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       ld, br, mr, mw, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [4:0] r, q;
    reset = 1'b1;
    idle();

    r = 5'($urandom_range(1, 31));
    q = (r == 5'd31) ? 5'd1 : r + 5'd1;
    vecs[0]  = '{"idle",        5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
    vecs[1]  = '{"lu_rs2",      5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_LU};
    vecs[2]  = '{"lu_rs1_rand", r,    q,    r,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_LU};
    vecs[3]  = '{"lu_rd0",      5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
    vecs[4]  = '{"lu_noload",   r,    r,    r,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
    vecs[5]  = '{"lu_nomatch",  q,    q,    r,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
    vecs[6]  = '{"br_beats_lu", 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_FL};
    vecs[7]  = '{"br_alone",    5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_FL};
    vecs[8]  = '{"ld_zerowait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_RUNR};
    vecs[9]  = '{"sd_zw_br",    5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_FLR};
    vecs[10] = '{"sd_zw_lu",    r,    5'd0, r,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_LUR};
    vecs[11] = '{"lu_both",     r,    r,    r,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};

    // Outputs while reset is held, before the state register has been cleared
    // by any edge we rely on: the combinational reset override must hold.
    @(negedge clk);
    check("reset_hold.out",
          {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Bubble, mem_req}, O_RST);
    check("reset_hold.err", {7'd0, mem_err}, 8'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Single-cycle vectors, all leaving the sequencer in RUN.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].ld, vecs[i].br,
            vecs[i].mr, vecs[i].mw, vecs[i].rdy);
      step(vecs[i].exp, RUN, 1'b0, vecs[i].name);
    end

    // Load-use costs one bubble: the next cycle the load has moved on.
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(O_LU, RUN, 1'b0, "lu_seq0");
    drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(O_RUN, RUN, 1'b0, "lu_seq1");

    // Memory wait: ready low 3 cycles then high.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(O_STALL, RUN, 1'b0, "mw_c1");
    step(O_STALL, MEM_WAIT, 1'b0, "mw_c2");
    step(O_STALL, MEM_WAIT, 1'b0, "mw_c3");
    mem_ready = 1'b1;
    step(O_RUNR, MEM_WAIT, 1'b0, "mw_c4");
    idle();
    step(O_RUN, RUN, 1'b0, "mw_c5");

    // Memory stall masks a branch until the release cycle.
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(O_STALL, RUN, 1'b0, "mask_c1");
    step(O_STALL, MEM_WAIT, 1'b0, "mask_c2");
    mem_ready = 1'b1;
    step(O_FLR, MEM_WAIT, 1'b0, "mask_rel");
    idle();
    step(O_RUN, RUN, 1'b0, "mask_after");

    // Reset in the middle of MEM_WAIT.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(O_STALL, RUN, 1'b0, "rstmw_c1");
    step(O_STALL, MEM_WAIT, 1'b0, "rstmw_c2");
    reset = 1'b1;
    step(O_RST, MEM_WAIT, 1'b0, "rstmw_rst");
    reset = 1'b0;
    idle();
    step(O_RUN, RUN, 1'b0, "rstmw_after");

    // Timeout: 4 MEM_WAIT cycles without ready, then HALT with mem_err.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(O_STALL, RUN, 1'b0, "to_run");
    for (int i = 0; i < 4; i++)
      step(O_STALL, MEM_WAIT, 1'b0, $sformatf("to_wait%0d", i));
    step(O_HALT, HALT, 1'b1, "to_halt");
    mem_ready = 1'b1;
    EX_branch_taken = 1'b1;
    step(O_HALT, HALT, 1'b1, "to_halt_ready");
    reset = 1'b1;
    step(O_RST, HALT, 1'b0, "to_reset");
    reset = 1'b0;
    idle();
    step(O_RUN, RUN, 1'b0, "to_recovered");

`ifdef PIPE_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(O_LU, RUN, 1'b0, "perf_lu");
    end
    for (int i = 0; i < 2; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(O_FL, RUN, 1'b0, "perf_br");
    end
    idle();
    @(negedge clk);
    check("perf_stalls3", {4'd0, stall_cycles}, 8'd3);
    check("perf_flush2", {4'd0, flush_count}, 8'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(O_FL, RUN, 1'b0, "perf_br_wrap");
    end
    idle();
    @(negedge clk);
    check("perf_flush_wrap", {4'd0, flush_count}, 8'd1);
    check("perf_stalls_kept", {4'd0, stall_cycles}, 8'd3);
    @(posedge clk);
    #1;
`endif

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
